// File: rtl/parity_frame_checker_pkg.sv
// Shared types and helpers for the multi-channel serial parity frame checker.
package parity_frame_checker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } ch_state_t;

    function automatic int bit_cnt_width(input int frame_len);
        return $clog2(frame_len + 1);
    endfunction

endpackage

// File: rtl/parity_frame_ch.sv
// Single-channel frame parity checker: IDLE/DATA/PAR FSM, running XOR and error counters.
module parity_frame_ch
    import parity_frame_checker_pkg::*;
#(
    parameter int FRAME_LEN = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mode_odd,
    input  logic                 clear_cnt,
    input  logic                 bit_in,
    input  logic                 bit_vld,
    input  logic                 sof,
    output logic                 busy,
    output logic                 parity_run,
    output logic                 frame_done,
    output logic                 frame_err,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int CW = bit_cnt_width(FRAME_LEN);
    localparam logic [CW-1:0] LAST_DATA = CW'(FRAME_LEN - 1);

    ch_state_t            state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic                 acc, acc_nxt;
    logic                 done_nxt, err_nxt;
    logic                 sticky_nxt;
    logic [ERR_CNT_W-1:0] err_cnt_nxt;

    // A valid sof restarts the frame from any state, abandoning a partial one silently.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        acc_nxt     = acc;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        sticky_nxt  = err_sticky;
        err_cnt_nxt = err_cnt;

        if (bit_vld) begin
            if (sof) begin
                acc_nxt   = bit_in;
                cnt_nxt   = CW'(1);
                state_nxt = (FRAME_LEN == 1) ? PAR : DATA;
            end else begin
                case (state)
                    DATA: begin
                        acc_nxt = acc ^ bit_in;
                        cnt_nxt = cnt + 1'b1;
                        if (cnt == LAST_DATA) begin
                            state_nxt = PAR;
                        end
                    end
                    PAR: begin
                        done_nxt  = 1'b1;
                        err_nxt   = (bit_in != (acc ^ mode_odd));
                        state_nxt = IDLE;
                    end
                    default: begin
                    end
                endcase
            end
        end

        // Clear wins over a coincident error so that error is neither counted nor made sticky.
        if (clear_cnt) begin
            sticky_nxt  = 1'b0;
            err_cnt_nxt = '0;
        end else if (err_nxt) begin
            sticky_nxt = 1'b1;
            if (err_cnt != {ERR_CNT_W{1'b1}}) begin
                err_cnt_nxt = err_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            acc        <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            err_sticky <= 1'b0;
            err_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            acc        <= acc_nxt;
            frame_done <= done_nxt;
            frame_err  <= err_nxt;
            err_sticky <= sticky_nxt;
            err_cnt    <= err_cnt_nxt;
        end
    end

    assign busy       = (state != IDLE);
    assign parity_run = acc;

endmodule

// File: rtl/parity_frame_checker.sv
// Multi-channel serial parity frame checker; one independent checker per channel.
module parity_frame_checker
    import parity_frame_checker_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int FRAME_LEN = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          mode_odd,
    input  logic                          clear_cnt,
    input  logic [NUM_CH-1:0]             bit_in,
    input  logic [NUM_CH-1:0]             bit_vld,
    input  logic [NUM_CH-1:0]             sof,
    output logic [NUM_CH-1:0]             busy,
    output logic [NUM_CH-1:0]             parity_run,
    output logic [NUM_CH-1:0]             frame_done,
    output logic [NUM_CH-1:0]             frame_err,
    output logic [NUM_CH-1:0]             err_sticky,
    output logic [NUM_CH*ERR_CNT_W-1:0]   err_cnt
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        parity_frame_ch #(
            .FRAME_LEN (FRAME_LEN),
            .ERR_CNT_W (ERR_CNT_W)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .mode_odd   (mode_odd),
            .clear_cnt  (clear_cnt),
            .bit_in     (bit_in[i]),
            .bit_vld    (bit_vld[i]),
            .sof        (sof[i]),
            .busy       (busy[i]),
            .parity_run (parity_run[i]),
            .frame_done (frame_done[i]),
            .frame_err  (frame_err[i]),
            .err_sticky (err_sticky[i]),
            .err_cnt    (err_cnt[i*ERR_CNT_W +: ERR_CNT_W])
        );
    end

endmodule

// File: tb/tb_parity_frame_checker.sv
// Self-checking bench for parity_frame_checker against a frame-level reference model.
module tb_parity_frame_checker;

    localparam int NUM_CH    = 4;
    localparam int FRAME_LEN = 8;
    localparam int ERR_CNT_W = 2;
    localparam int CNT_MAX   = (1 << ERR_CNT_W) - 1;

    logic clk       = 1'b0;
    logic reset     = 1'b0;
    logic mode_odd  = 1'b0;
    logic clear_cnt = 1'b0;
    logic [NUM_CH-1:0] bit_in  = '0;
    logic [NUM_CH-1:0] bit_vld = '0;
    logic [NUM_CH-1:0] sof     = '0;
    logic [NUM_CH-1:0] busy, parity_run, frame_done, frame_err, err_sticky;
    logic [NUM_CH*ERR_CNT_W-1:0] err_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: bits collected and ones seen per channel, plus status.
    int m_len    [NUM_CH];
    int m_ones   [NUM_CH];
    int m_errs   [NUM_CH];
    logic [NUM_CH-1:0] m_busy, m_run, m_done, m_err, m_sticky;
    logic [NUM_CH*ERR_CNT_W-1:0] m_cnt;

    parity_frame_checker #(
        .NUM_CH    (NUM_CH),
        .FRAME_LEN (FRAME_LEN),
        .ERR_CNT_W (ERR_CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mode_odd   (mode_odd),
        .clear_cnt  (clear_cnt),
        .bit_in     (bit_in),
        .bit_vld    (bit_vld),
        .sof        (sof),
        .busy       (busy),
        .parity_run (parity_run),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_len[c]  = 0;
            m_ones[c] = 0;
            m_errs[c] = 0;
        end
        m_busy   = '0;
        m_run    = '0;
        m_done   = '0;
        m_err    = '0;
        m_sticky = '0;
        m_cnt    = '0;
    endtask

    // Advance the model with the current inputs, then let the DUT take the same edge.
    task automatic tick();
        logic [NUM_CH-1:0] nd, ne;
        nd = '0;
        ne = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (bit_vld[c]) begin
                if (sof[c]) begin
                    m_busy[c] = 1'b1;
                    m_len[c]  = 1;
                    m_ones[c] = int'(bit_in[c]);
                    m_run[c]  = (m_ones[c] % 2) == 1;
                end else if (m_busy[c] && m_len[c] < FRAME_LEN) begin
                    m_len[c]  = m_len[c] + 1;
                    m_ones[c] = m_ones[c] + int'(bit_in[c]);
                    m_run[c]  = (m_ones[c] % 2) == 1;
                end else if (m_busy[c]) begin
                    nd[c]     = 1'b1;
                    ne[c]     = ((m_ones[c] + int'(bit_in[c])) % 2) != int'(mode_odd);
                    m_busy[c] = 1'b0;
                end
            end
            if (clear_cnt) begin
                m_errs[c]   = 0;
                m_sticky[c] = 1'b0;
            end else if (ne[c]) begin
                m_sticky[c] = 1'b1;
                if (m_errs[c] < CNT_MAX) m_errs[c] = m_errs[c] + 1;
            end
            m_cnt[c*ERR_CNT_W +: ERR_CNT_W] = ERR_CNT_W'(m_errs[c]);
        end
        m_done = nd;
        m_err  = ne;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic vld, input logic s, input logic b);
        bit_vld[c] = vld;
        sof[c]     = s;
        bit_in[c]  = b;
    endtask

    // Data bit 0 goes first; clr drives clear_cnt during the parity-bit cycle.
    task automatic send_frame(input int c, input logic [FRAME_LEN-1:0] data,
                              input logic par, input logic clr);
        for (int i = 0; i < FRAME_LEN; i++) begin
            set_ch(c, 1'b1, i == 0, data[i]);
            tick();
        end
        set_ch(c, 1'b1, 1'b0, par);
        clear_cnt = clr;
        tick();
        set_ch(c, 1'b0, 1'b0, 1'b0);
        clear_cnt = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        total++; if (busy !== '0 || parity_run !== '0) begin bad++;
            $display("[TB] FAIL reset_busy_run: busy=%b run=%b expected 0", busy, parity_run); end
        total++; if (frame_done !== '0 || frame_err !== '0) begin bad++;
            $display("[TB] FAIL reset_done_err: done=%b err=%b expected 0", frame_done, frame_err); end
        total++; if (err_sticky !== '0 || err_cnt !== '0) begin bad++;
            $display("[TB] FAIL reset_sticky_cnt: sticky=%b cnt=%h expected 0", err_sticky, err_cnt); end
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_even();
        mode_odd = 1'b0;
        send_frame(0, 8'h4D, 1'b0, 1'b0);
        total++; if (frame_done !== 4'b0001 || frame_err !== 4'b0000) begin bad++;
            $display("[TB] FAIL even_good: done=%b err=%b expected 0001/0000", frame_done, frame_err); end
        total++; if (err_cnt[0 +: ERR_CNT_W] !== ERR_CNT_W'(0)) begin bad++;
            $display("[TB] FAIL even_good_cnt: cnt=%0d expected 0", err_cnt[0 +: ERR_CNT_W]); end
        total++; if (busy !== m_busy || parity_run !== m_run) begin bad++;
            $display("[TB] FAIL even_model: busy=%b run=%b expected %b/%b", busy, parity_run, m_busy, m_run); end
        tick();
        total++; if (frame_done !== '0) begin bad++;
            $display("[TB] FAIL done_pulse_width: done=%b expected 0", frame_done); end
        send_frame(0, 8'h4D, 1'b1, 1'b0);
        total++; if (frame_done !== 4'b0001 || frame_err !== 4'b0001) begin bad++;
            $display("[TB] FAIL even_bad: done=%b err=%b expected 0001/0001", frame_done, frame_err); end
        total++; if (err_sticky[0] !== 1'b1 || err_cnt[0 +: ERR_CNT_W] !== ERR_CNT_W'(1)) begin bad++;
            $display("[TB] FAIL even_bad_cnt: sticky=%b cnt=%0d expected 1/1", err_sticky[0], err_cnt[0 +: ERR_CNT_W]); end
        tick();
        total++; if (frame_err !== '0 || err_cnt !== m_cnt) begin bad++;
            $display("[TB] FAIL even_after: err=%b cnt=%h expected 0/%h", frame_err, err_cnt, m_cnt); end
    endtask

    task automatic test_odd();
        logic [FRAME_LEN-1:0] d;
        d = 8'h07;
        mode_odd = 1'b1;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < FRAME_LEN; i++) begin
                set_ch(0, 1'b1, i == 0, d[i]);
                tick();
                if (i == 2) begin
                    total++; if (parity_run[0] !== 1'b1 || parity_run !== m_run) begin bad++;
                        $display("[TB] FAIL odd_run_bit3: run=%b expected 1 (model %b)", parity_run, m_run); end
                end
            end
            set_ch(0, 1'b1, 1'b0, p == 1);
            tick();
            set_ch(0, 1'b0, 1'b0, 1'b0);
            total++; if (frame_done[0] !== 1'b1 || frame_err[0] !== (p == 1)) begin bad++;
                $display("[TB] FAIL odd_parity%0d: done=%b err=%b expected 1/%0d", p, frame_done[0], frame_err[0], p); end
            total++; if (err_cnt !== m_cnt || err_sticky !== m_sticky) begin bad++;
                $display("[TB] FAIL odd_cnt%0d: cnt=%h sticky=%b expected %h/%b", p, err_cnt, err_sticky, m_cnt, m_sticky); end
        end
    endtask

    task automatic test_abort();
        logic [FRAME_LEN-1:0] d;
        int dones, errs;
        dones = 0;
        errs  = 0;
        d = FRAME_LEN'($urandom);
        mode_odd = 1'b0;
        for (int k = 0; k < 5 + FRAME_LEN + 1; k++) begin
            if (k < 5) set_ch(0, 1'b1, k == 0, 1'($urandom));
            else if (k - 5 < FRAME_LEN) set_ch(0, 1'b1, k == 5, d[k-5]);
            else set_ch(0, 1'b1, 1'b0, ^d);
            tick();
            if (frame_done[0]) dones++;
            if (frame_err[0]) errs++;
            if (k < 5 + FRAME_LEN) begin
                total++; if (busy[0] !== 1'b1) begin bad++;
                    $display("[TB] FAIL abort_busy: cycle %0d busy=%b expected 1", k, busy[0]); end
            end
        end
        set_ch(0, 1'b0, 1'b0, 1'b0);
        tick();
        if (frame_done[0]) dones++;
        if (frame_err[0]) errs++;
        total++; if (dones != 1 || errs != 0) begin bad++;
            $display("[TB] FAIL abort_count: dones=%0d errs=%0d expected 1/0", dones, errs); end
        total++; if (err_cnt !== m_cnt || busy !== m_busy) begin bad++;
            $display("[TB] FAIL abort_model: cnt=%h busy=%b expected %h/%b", err_cnt, busy, m_cnt, m_busy); end
    endtask

    task automatic test_back_to_back();
        int done1, done2, p;
        done1 = 0;
        done2 = 0;
        mode_odd = 1'($urandom_range(0, 1));
        for (int k = 0; k < 60; k++) begin
            if (k < 3 * (FRAME_LEN + 1)) begin
                p = k % (FRAME_LEN + 1);
                set_ch(2, 1'b1, p == 0, 1'($urandom));
            end else begin
                set_ch(2, 1'b0, 1'b0, 1'($urandom));
            end
            if (k % 3 == 0 && k / 3 < 2 * (FRAME_LEN + 1)) begin
                p = (k / 3) % (FRAME_LEN + 1);
                set_ch(1, 1'b1, p == 0, 1'($urandom));
            end else begin
                set_ch(1, 1'b0, 1'($urandom), 1'($urandom));
            end
            set_ch(3, 1'($urandom), 1'b0, 1'($urandom));
            tick();
            if (frame_done[1]) done1++;
            if (frame_done[2]) done2++;
            total++; if (busy !== m_busy || parity_run !== m_run) begin bad++;
                $display("[TB] FAIL b2b_state: cycle %0d busy=%b run=%b expected %b/%b", k, busy, parity_run, m_busy, m_run); end
            total++; if (frame_done !== m_done || frame_err !== m_err) begin bad++;
                $display("[TB] FAIL b2b_done: cycle %0d done=%b err=%b expected %b/%b", k, frame_done, frame_err, m_done, m_err); end
            total++; if (err_sticky !== m_sticky || err_cnt !== m_cnt) begin bad++;
                $display("[TB] FAIL b2b_cnt: cycle %0d sticky=%b cnt=%h expected %b/%h", k, err_sticky, err_cnt, m_sticky, m_cnt); end
        end
        bit_vld = '0;
        sof     = '0;
        total++; if (done1 != 2 || done2 != 3) begin bad++;
            $display("[TB] FAIL b2b_frames: ch1=%0d ch2=%0d expected 2/3", done1, done2); end
    endtask

    task automatic test_saturate();
        logic [FRAME_LEN-1:0] d;
        mode_odd = 1'b0;
        for (int n = 0; n < 5; n++) begin
            d = FRAME_LEN'($urandom);
            send_frame(3, d, ~(^d), 1'b0);
            total++; if (frame_err[3] !== 1'b1 || err_cnt !== m_cnt) begin bad++;
                $display("[TB] FAIL sat_frame%0d: err=%b cnt=%h expected 1/%h", n, frame_err[3], err_cnt, m_cnt); end
        end
        total++; if (err_cnt[3*ERR_CNT_W +: ERR_CNT_W] !== ERR_CNT_W'(CNT_MAX)) begin bad++;
            $display("[TB] FAIL sat_value: cnt=%0d expected %0d", err_cnt[3*ERR_CNT_W +: ERR_CNT_W], CNT_MAX); end
        d = FRAME_LEN'($urandom);
        send_frame(3, d, ~(^d), 1'b1);
        total++; if (frame_err[3] !== 1'b1 || frame_done[3] !== 1'b1) begin bad++;
            $display("[TB] FAIL clear_pulse: done=%b err=%b expected 1/1", frame_done[3], frame_err[3]); end
        total++; if (err_cnt !== '0 || err_sticky !== '0) begin bad++;
            $display("[TB] FAIL clear_priority: cnt=%h sticky=%b expected 0/0", err_cnt, err_sticky); end
    endtask

    task automatic test_reset_mid();
        logic [FRAME_LEN-1:0] d;
        mode_odd = 1'b0;
        d = FRAME_LEN'($urandom);
        send_frame(1, d, ^d, 1'b0);
        for (int i = 0; i < 4; i++) begin
            set_ch(0, 1'b1, i == 0, 1'b1);
            tick();
        end
        set_ch(0, 1'b0, 1'b0, 1'b0);
        total++; if (busy[0] !== 1'b1 || parity_run[0] !== 1'b0) begin bad++;
            $display("[TB] FAIL pre_reset: busy=%b run=%b expected 1/0", busy[0], parity_run[0]); end
        #3;
        reset = 1'b0;
        #1;
        total++; if (busy !== '0 || parity_run !== '0 || frame_done !== '0) begin bad++;
            $display("[TB] FAIL async_reset: busy=%b run=%b done=%b expected 0", busy, parity_run, frame_done); end
        total++; if (err_sticky !== '0 || err_cnt !== '0 || frame_err !== '0) begin bad++;
            $display("[TB] FAIL async_reset_cnt: sticky=%b cnt=%h err=%b expected 0", err_sticky, err_cnt, frame_err); end
        model_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        d = FRAME_LEN'($urandom);
        send_frame(0, d, ^d ^ mode_odd, 1'b0);
        total++; if (frame_done !== 4'b0001 || frame_err !== '0 || frame_done !== m_done) begin bad++;
            $display("[TB] FAIL post_reset_frame: done=%b err=%b expected 0001/0000", frame_done, frame_err); end
        total++; if (parity_run !== m_run || err_cnt !== m_cnt) begin bad++;
            $display("[TB] FAIL post_reset_model: run=%b cnt=%h expected %b/%h", parity_run, err_cnt, m_run, m_cnt); end
    endtask

    initial begin
        test_reset();
        test_even();
        test_odd();
        test_abort();
        test_back_to_back();
        test_saturate();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
